// File: rtl/algo_ncor2a_1r1w_sat.sv
// ============================================================================
// Module   : algo_ncor2a_1r1w_sat
// Purpose  : Multi-channel SRAM-backed counter engine (add/read/set, sat/wrap)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module algo_ncor2a_1r1w_sat #(
    parameter int WIDTH      = 32,
    parameter int NUMCTPT    = 2,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int SRAM_DELAY = 2,
    parameter int SATURATE   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2*NUMCTPT-1:0]       ct_op,
    input  logic [BITADDR*NUMCTPT-1:0] ct_adr,
    input  logic [WIDTH*NUMCTPT-1:0]   imm,
    output logic [NUMCTPT-1:0]         ct_vld,
    output logic [WIDTH*NUMCTPT-1:0]   ct_dout,
    output logic [NUMCTPT-1:0]         ct_sat,
    output logic [NUMCTPT-1:0]         ct_serr,
    output logic [NUMCTPT-1:0]         ct_derr,
    output logic                       ready,
    output logic [NUMCTPT-1:0]         t1_writeA,
    output logic [BITADDR*NUMCTPT-1:0] t1_addrA,
    output logic [WIDTH*NUMCTPT-1:0]   t1_dinA,
    output logic [NUMCTPT-1:0]         t1_readB,
    output logic [BITADDR*NUMCTPT-1:0] t1_addrB,
    input  logic [WIDTH*NUMCTPT-1:0]   t1_doutB,
    input  logic [NUMCTPT-1:0]         t1_serrB,
    input  logic [NUMCTPT-1:0]         t1_derrB
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SET = 2'b11;

    localparam logic [BITADDR-1:0] LAST_ADDR = BITADDR'(NUMADDR - 1);

    logic [1:0]         state_q, state_d;
    logic [BITADDR-1:0] ptr_q, ptr_d;
    logic               sweep;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE:  state_d = ST_SWEEP;
            ST_SWEEP: begin
                if (ptr_q == LAST_ADDR) state_d = ST_READY;
                else                    ptr_d   = ptr_q + 1'b1;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sweep = (state_q == ST_SWEEP);
    assign ready = (state_q == ST_READY);

    for (genvar c = 0; c < NUMCTPT; c++) begin : g_ch
        logic [1:0]         op_in;
        logic [BITADDR-1:0] adr_in;
        logic [WIDTH-1:0]   imm_in;
        logic [WIDTH-1:0]   rdata;

        logic [SRAM_DELAY-1:0][1:0]         pop_q;
        logic [SRAM_DELAY-1:0][BITADDR-1:0] padr_q;
        logic [SRAM_DELAY-1:0][WIDTH-1:0]   pimm_q;

        logic [SRAM_DELAY-1:0]              hv_q;
        logic [SRAM_DELAY-1:0][BITADDR-1:0] hadr_q;
        logic [SRAM_DELAY-1:0][WIDTH-1:0]   hval_q;

        logic [1:0]         cop;
        logic [BITADDR-1:0] cadr;
        logic [WIDTH-1:0]   cimm;
        logic               fwd, serr_c, derr_c, sat_c, cvld, we;
        logic [WIDTH-1:0]   base, res;
        logic [WIDTH+1:0]   sum;

        logic               vld_q, sat_q, serr_q, derr_q;
        logic [WIDTH-1:0]   dout_q;

        assign op_in  = ready ? ct_op[c*2 +: 2] : 2'b00;
        assign adr_in = ct_adr[c*BITADDR +: BITADDR];
        assign imm_in = imm[c*WIDTH +: WIDTH];
        assign rdata  = t1_doutB[c*WIDTH +: WIDTH];

        assign cop  = pop_q[SRAM_DELAY-1];
        assign cadr = padr_q[SRAM_DELAY-1];
        assign cimm = pimm_q[SRAM_DELAY-1];

        always_comb begin
            fwd  = 1'b0;
            base = rdata;
            // Scan oldest to youngest so the most recent matching write-back wins.
            for (int s = SRAM_DELAY - 1; s >= 0; s--) begin
                if (hv_q[s] && (hadr_q[s] == cadr)) begin
                    fwd  = 1'b1;
                    base = hval_q[s];
                end
            end
            serr_c = !fwd && t1_serrB[c];
            derr_c = !fwd && t1_derrB[c];
            sum    = {2'b00, base} + {{2{cimm[WIDTH-1]}}, cimm};
            sat_c  = 1'b0;
            res    = base;
            case (cop)
                OP_ADD: begin
                    if ((SATURATE != 0) && sum[WIDTH+1]) begin
                        res   = '0;
                        sat_c = 1'b1;
                    end else if ((SATURATE != 0) && sum[WIDTH]) begin
                        res   = '1;
                        sat_c = 1'b1;
                    end else begin
                        res   = sum[WIDTH-1:0];
                    end
                end
                OP_SET:  res = cimm;
                default: res = base;
            endcase
            // An uncorrectable fetch scrubs the counter; a set still lands its value.
            if (derr_c) begin
                res   = (cop == OP_SET) ? cimm : '0;
                sat_c = 1'b0;
            end
            cvld = (cop != 2'b00);
            we   = cvld && ((cop == OP_ADD) || (cop == OP_SET) || derr_c);
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pop_q  <= '0;
                padr_q <= '0;
                pimm_q <= '0;
                hv_q   <= '0;
                hadr_q <= '0;
                hval_q <= '0;
                vld_q  <= 1'b0;
                dout_q <= '0;
                sat_q  <= 1'b0;
                serr_q <= 1'b0;
                derr_q <= 1'b0;
            end else begin
                pop_q[0]  <= op_in;
                padr_q[0] <= adr_in;
                pimm_q[0] <= imm_in;
                hv_q[0]   <= we;
                hadr_q[0] <= cadr;
                hval_q[0] <= res;
                for (int s = 1; s < SRAM_DELAY; s++) begin
                    pop_q[s]  <= pop_q[s-1];
                    padr_q[s] <= padr_q[s-1];
                    pimm_q[s] <= pimm_q[s-1];
                    hv_q[s]   <= hv_q[s-1];
                    hadr_q[s] <= hadr_q[s-1];
                    hval_q[s] <= hval_q[s-1];
                end
                vld_q <= cvld;
                if (cvld) begin
                    dout_q <= res;
                    sat_q  <= sat_c;
                    serr_q <= serr_c;
                    derr_q <= derr_c;
                end
            end
        end

        assign t1_readB[c]                     = (op_in != 2'b00);
        assign t1_addrB[c*BITADDR +: BITADDR]  = adr_in;
        assign t1_writeA[c]                    = sweep || we;
        assign t1_addrA[c*BITADDR +: BITADDR]  = sweep ? ptr_q : cadr;
        assign t1_dinA[c*WIDTH +: WIDTH]       = sweep ? '0 : res;

        assign ct_vld[c]                 = vld_q;
        assign ct_dout[c*WIDTH +: WIDTH] = dout_q;
        assign ct_sat[c]                 = sat_q;
        assign ct_serr[c]                = serr_q;
        assign ct_derr[c]                = derr_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_algo_ncor2a_1r1w_sat.sv
// ============================================================================
// Module   : tb_algo_ncor2a_1r1w_sat
// Purpose  : Directed self-checking bench for the counter engine with SRAM model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_algo_ncor2a_1r1w_sat;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_SET  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  ct_op = '0;
    logic [25:0] ct_adr = '0;
    logic [63:0] imm = '0;
    logic [1:0]  ct_vld, ct_sat, ct_serr, ct_derr;
    logic [63:0] ct_dout;
    logic        ready;
    logic [1:0]  t1_writeA, t1_readB;
    logic [25:0] t1_addrA, t1_addrB;
    logic [63:0] t1_dinA, t1_doutB;
    logic [1:0]  t1_serrB = '0;
    logic [1:0]  t1_derrB = '0;

    logic [1:0]  op2 = '0;
    logic [3:0]  adr2 = '0;
    logic [31:0] imm2 = '0;
    logic [0:0]  vld2, sat2, serr2, derr2, wa2, rb2;
    logic [31:0] dout2, din2, doutb2;
    logic [3:0]  addra2, addrb2;
    logic        ready2;
    logic [0:0]  noerr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    algo_ncor2a_1r1w_sat dut (
        .clk(clk), .rst(rst), .ct_op(ct_op), .ct_adr(ct_adr), .imm(imm),
        .ct_vld(ct_vld), .ct_dout(ct_dout), .ct_sat(ct_sat), .ct_serr(ct_serr),
        .ct_derr(ct_derr), .ready(ready), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA),
        .t1_dinA(t1_dinA), .t1_readB(t1_readB), .t1_addrB(t1_addrB),
        .t1_doutB(t1_doutB), .t1_serrB(t1_serrB), .t1_derrB(t1_derrB)
    );

    algo_ncor2a_1r1w_sat #(
        .WIDTH(32), .NUMCTPT(1), .NUMADDR(16), .BITADDR(4), .SRAM_DELAY(2), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .ct_op(op2), .ct_adr(adr2), .imm(imm2),
        .ct_vld(vld2), .ct_dout(dout2), .ct_sat(sat2), .ct_serr(serr2),
        .ct_derr(derr2), .ready(ready2), .t1_writeA(wa2), .t1_addrA(addra2),
        .t1_dinA(din2), .t1_readB(rb2), .t1_addrB(addrb2),
        .t1_doutB(doutb2), .t1_serrB(noerr), .t1_derrB(noerr)
    );

    // 1R1W macro model: 2-cycle read latency, read-during-write returns old data.
    logic [31:0] mem [2][8192];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [31:0] mem2 [16];
    logic [31:0] rd0b, rd1b;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (t1_readB[c]) rd0[c] <= mem[c][t1_addrB[c*13 +: 13]];
            rd1[c] <= rd0[c];
            if (t1_writeA[c]) mem[c][t1_addrA[c*13 +: 13]] <= t1_dinA[c*32 +: 32];
        end
        if (rb2[0]) rd0b <= mem2[addrb2];
        rd1b <= rd0b;
        if (wa2[0]) mem2[addra2] <= din2;
    end

    assign t1_doutB = {rd1[1], rd1[0]};
    assign doutb2   = rd1b;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the sweep to start, then checks its length and content.
    task automatic sweep_check(input string tag);
        int n;
        int bad;
        n = 0;
        while (t1_writeA != 2'b11 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_start"}, 64'(t1_writeA), 64'h3);
        n   = 0;
        bad = 0;
        while (!ready && n < 20000) begin
            if (t1_writeA != 2'b11 || t1_dinA != '0 || t1_readB != '0 || ct_vld != '0
                || t1_addrA[12:0] != n[12:0] || t1_addrA[25:13] != n[12:0])
                bad++;
            tick();
            n++;
        end
        chk({tag, "_len"}, 64'(n), 64'd8192);
        chk({tag, "_content"}, 64'(bad), 64'd0);
        chk({tag, "_ready"}, 64'(ready), 64'd1);
        chk({tag, "_idle_wr"}, 64'(t1_writeA), 64'd0);
    endtask

    task automatic do_op(input string tag, input int ch, input logic [1:0] op,
                         input logic [12:0] a, input logic [31:0] im,
                         input logic inj_s, input logic inj_d,
                         input logic [31:0] exp_d, input logic exp_sat,
                         input logic exp_se, input logic exp_de, input logic exp_wa);
        logic wa;
        ct_op[ch*2 +: 2]   = op;
        ct_adr[ch*13 +: 13] = a;
        imm[ch*32 +: 32]   = im;
        tick();
        ct_op = '0;
        tick();
        t1_serrB[ch] = inj_s;
        t1_derrB[ch] = inj_d;
        #1;
        wa = t1_writeA[ch];
        tick();
        t1_serrB = '0;
        t1_derrB = '0;
        chk({tag, "_vld"}, 64'(ct_vld[ch]), 64'd1);
        chk({tag, "_dout"}, 64'(ct_dout[ch*32 +: 32]), 64'(exp_d));
        chk({tag, "_sat"}, 64'(ct_sat[ch]), 64'(exp_sat));
        chk({tag, "_serr"}, 64'(ct_serr[ch]), 64'(exp_se));
        chk({tag, "_derr"}, 64'(ct_derr[ch]), 64'(exp_de));
        chk({tag, "_wr"}, 64'(wa), 64'(exp_wa));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_vld", 64'(ct_vld), 64'd0);
        chk("rst_wr", 64'(t1_writeA), 64'd0);
        chk("rst_rd", 64'(t1_readB), 64'd0);
        rst = 1'b1;
        sweep_check("init");

        do_op("rd5", 0, OP_READ, 13'd5, 32'd0, 0, 0, 32'd0, 0, 0, 0, 0);

        // Five back-to-back +1 adds to one address exercise both forwarding depths.
        for (int i = 0; i < 8; i++) begin
            if (i >= 3) begin
                chk("b2b_vld", 64'(ct_vld[0]), 64'd1);
                chk("b2b_dout", 64'(ct_dout[31:0]), 64'(i - 2));
            end
            ct_op[1:0]  = (i < 5) ? OP_ADD : OP_IDLE;
            ct_adr[12:0] = 13'd7;
            imm[31:0]   = 32'd1;
            tick();
        end
        chk("b2b_end", 64'(ct_vld[0]), 64'd0);
        chk("b2b_mem", 64'(mem[0][7]), 64'd5);

        do_op("sat_set", 0, OP_SET, 13'd3, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE, 0, 0, 0, 1);
        do_op("sat_hi",  0, OP_ADD, 13'd3, 32'd5,         0, 0, 32'hFFFF_FFFF, 1, 0, 0, 1);
        do_op("sat_neg", 0, OP_ADD, 13'd3, 32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 1);
        do_op("sat_one", 0, OP_SET, 13'd3, 32'd1,         0, 0, 32'd1,         0, 0, 0, 1);
        do_op("sat_lo",  0, OP_ADD, 13'd3, 32'hFFFF_FFFE, 0, 0, 32'd0,         1, 0, 0, 1);

        do_op("err_set", 1, OP_SET,  13'd9, 32'd42, 0, 0, 32'd42, 0, 0, 0, 1);
        do_op("derr",    1, OP_READ, 13'd9, 32'd0,  0, 1, 32'd0,  0, 0, 1, 1);
        chk("derr_mem", 64'(mem[1][9]), 64'd0);
        do_op("err_set2", 1, OP_SET,  13'd9, 32'd42, 0, 0, 32'd42, 0, 0, 0, 1);
        do_op("serr",     1, OP_READ, 13'd9, 32'd0,  1, 0, 32'd42, 0, 1, 0, 0);

        do_op("ind_s0", 0, OP_SET, 13'd11, 32'd100, 0, 0, 32'd100, 0, 0, 0, 1);
        do_op("ind_s1", 1, OP_SET, 13'd11, 32'd200, 0, 0, 32'd200, 0, 0, 0, 1);
        ct_op  = {OP_ADD, OP_ADD};
        ct_adr = {13'd11, 13'd11};
        imm    = {32'd7, 32'd3};
        tick();
        ct_op = '0;
        tick();
        tick();
        chk("ind_vld", 64'(ct_vld), 64'd3);
        chk("ind_ch0", 64'(ct_dout[31:0]), 64'd103);
        chk("ind_ch1", 64'(ct_dout[63:32]), 64'd207);

        chk("wrap_ready", 64'(ready2), 64'd1);
        op2 = OP_SET; adr2 = 4'd2; imm2 = 32'hFFFF_FFFF;
        tick();
        op2 = OP_IDLE;
        tick();
        tick();
        chk("wrap_set", 64'(dout2), 64'hFFFF_FFFF);
        op2 = OP_ADD; imm2 = 32'd2;
        tick();
        op2 = OP_IDLE;
        tick();
        tick();
        chk("wrap_vld", 64'(vld2), 64'd1);
        chk("wrap_dout", 64'(dout2), 64'd1);
        chk("wrap_sat", 64'(sat2), 64'd0);

        ct_op  = {OP_ADD, OP_ADD};
        ct_adr = {13'd20, 13'd20};
        imm    = {32'd9, 32'd4};
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_vld", 64'(ct_vld), 64'd0);
        chk("mrst_wr", 64'(t1_writeA), 64'd0);
        chk("mrst_ready", 64'(ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_hold", 64'({ct_vld, t1_writeA, t1_readB}), 64'd0);
        end
        ct_op = '0;
        rst   = 1'b1;
        sweep_check("resweep");
        do_op("post_rd", 0, OP_READ, 13'd20, 32'd0, 0, 0, 32'd0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
